// File: rtl/i3c_pkg.sv
// Shared I3C package: helpers used by the TTI-to-transmit-path datapath blocks.
package i3c_pkg;

  // Number of output beats needed to carry nbytes bytes when each beat holds out_bytes bytes.
  function automatic int unsigned wd_beat_count(input int unsigned nbytes,
                                                input int unsigned out_bytes);
    return (nbytes + out_bytes - 1) / out_bytes;
  endfunction

endpackage

// File: rtl/width_downsizer.sv
// InWidth-to-OutWidth stream downsizer with packet framing and flush.
// Beat order selectable with WIDTH_DOWNSIZER_MSB_FIRST_EN (default: least-significant beat first).
module width_downsizer
  import i3c_pkg::*;
#(
  parameter int unsigned InWidth  = 32,
  parameter int unsigned OutWidth = 8
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            sink_valid_i,
  output logic                            sink_ready_o,
  input  logic [InWidth-1:0]              sink_data_i,
  input  logic                            sink_last_i,
  input  logic [$clog2(InWidth/8)-1:0]    sink_nbytes_i,
  output logic                            source_valid_o,
  input  logic                            source_ready_i,
  output logic [OutWidth-1:0]             source_data_o,
  output logic                            source_last_o,
  input  logic                            source_flush_i
);

  localparam int unsigned InBytes  = InWidth / 8;
  localparam int unsigned OutBytes = OutWidth / 8;
  localparam int unsigned Ratio    = InWidth / OutWidth;
  localparam int unsigned CntW     = $clog2(Ratio) + 1;

  if (InWidth % OutWidth != 0) begin : g_chk_ratio
    $error("width_downsizer: InWidth must be a multiple of OutWidth");
  end
  if (OutWidth % 8 != 0) begin : g_chk_bytes
    $error("width_downsizer: OutWidth must be a multiple of 8");
  end
  if (InWidth <= OutWidth) begin : g_chk_down
    $error("width_downsizer: InWidth must exceed OutWidth");
  end

  // Keeps the nb bytes that are transmitted first; everything else is zeroed.
  function automatic logic [InWidth-1:0] byte_mask(input int unsigned nb);
    logic [InWidth-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < InBytes; i++) begin
`ifdef WIDTH_DOWNSIZER_MSB_FIRST_EN
      if (i + nb >= InBytes) m[i*8 +: 8] = 8'hFF;
`else
      if (i < nb) m[i*8 +: 8] = 8'hFF;
`endif
    end
    return m;
  endfunction

  logic [CntW-1:0]    bcnt_q, bcnt_d;
  logic [InWidth-1:0] shreg_q, shreg_d;
  logic               last_q, last_d;

  int unsigned        nb_eff;
  logic [CntW-1:0]    load_beats;
  logic               load, accept;

  always_comb begin
    nb_eff = InBytes;
    if (sink_last_i && (sink_nbytes_i != '0)) nb_eff = 32'(sink_nbytes_i);
    load_beats = CntW'(wd_beat_count(nb_eff, OutBytes));
  end

  // Ready may follow source_ready_i in the same cycle so the next word loads with no bubble.
  assign sink_ready_o   = ~source_flush_i &
                          ((bcnt_q == '0) | ((bcnt_q == CntW'(1)) & source_ready_i));
  assign source_valid_o = (bcnt_q != '0);
  assign source_last_o  = last_q & (bcnt_q == CntW'(1));
  assign load           = sink_valid_i & sink_ready_o;
  assign accept         = source_valid_o & source_ready_i;

`ifdef WIDTH_DOWNSIZER_MSB_FIRST_EN
  assign source_data_o = shreg_q[InWidth-1 -: OutWidth];
`else
  assign source_data_o = shreg_q[OutWidth-1:0];
`endif

  always_comb begin
    bcnt_d  = bcnt_q;
    shreg_d = shreg_q;
    last_d  = last_q;
    if (source_flush_i) begin
      bcnt_d  = '0;
      shreg_d = '0;
      last_d  = 1'b0;
    end else if (load) begin
      bcnt_d  = load_beats;
      shreg_d = sink_data_i & byte_mask(nb_eff);
      last_d  = sink_last_i;
    end else if (accept) begin
      bcnt_d  = bcnt_q - CntW'(1);
`ifdef WIDTH_DOWNSIZER_MSB_FIRST_EN
      shreg_d = shreg_q << OutWidth;
`else
      shreg_d = shreg_q >> OutWidth;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bcnt_q  <= '0;
      shreg_q <= '0;
      last_q  <= 1'b0;
    end else begin
      bcnt_q  <= bcnt_d;
      shreg_q <= shreg_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_width_downsizer.sv
// Self-checking bench for width_downsizer: 32->8 and 32->16 instances, directed plus randomized traffic.
module tb_width_downsizer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        a_sv, a_srdy, a_sl, a_vld, a_rdy, a_last, a_fl;
  logic [31:0] a_sd;
  logic [1:0]  a_snb;
  logic [7:0]  a_dat;

  logic        b_sv, b_srdy, b_sl, b_vld, b_rdy, b_last, b_fl;
  logic [31:0] b_sd;
  logic [1:0]  b_snb;
  logic [15:0] b_dat;

  width_downsizer #(.InWidth(32), .OutWidth(8)) dut_a (
    .clk_i(clk), .rst_ni(rst_n),
    .sink_valid_i(a_sv), .sink_ready_o(a_srdy), .sink_data_i(a_sd),
    .sink_last_i(a_sl), .sink_nbytes_i(a_snb),
    .source_valid_o(a_vld), .source_ready_i(a_rdy), .source_data_o(a_dat),
    .source_last_o(a_last), .source_flush_i(a_fl)
  );

  width_downsizer #(.InWidth(32), .OutWidth(16)) dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .sink_valid_i(b_sv), .sink_ready_o(b_srdy), .sink_data_i(b_sd),
    .sink_last_i(b_sl), .sink_nbytes_i(b_snb),
    .source_valid_o(b_vld), .source_ready_i(b_rdy), .source_data_o(b_dat),
    .source_last_o(b_last), .source_flush_i(b_fl)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]  w1 [4];
  logic [7:0]  w2 [4];
  logic [7:0]  pe [3];
  logic [15:0] p16 [2];
  logic [7:0]  ee_first;

  typedef struct packed { logic [7:0] d; logic l; } beat_t;
  beat_t q[$];

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++; if (a_srdy !== 1'b1) begin errors++; $display("FAIL reset_sink_ready got %b exp 1", a_srdy); end
    checks++; if (a_vld !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", a_vld); end
    checks++; if (a_dat !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", a_dat); end
    checks++; if (a_last !== 1'b0) begin errors++; $display("FAIL reset_last got %b exp 0", a_last); end
    checks++; if (b_vld !== 1'b0 || b_dat !== 16'h0) begin errors++; $display("FAIL reset_b got vld %b data %h exp 0/0000", b_vld, b_dat); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_word();
    @(negedge clk);
    a_sv = 1'b1; a_sd = 32'h44332211; a_sl = 1'b0; a_snb = 2'd0; a_rdy = 1'b1; a_fl = 1'b0;
    #1;
    checks++; if (a_srdy !== 1'b1) begin errors++; $display("FAIL single_sink_ready got %b exp 1", a_srdy); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      a_sv = 1'b0;
      #1;
      checks++; if (a_vld !== 1'b1) begin errors++; $display("FAIL single_valid beat %0d got %b exp 1", k, a_vld); end
      checks++; if (a_dat !== w1[k]) begin errors++; $display("FAIL single_data beat %0d got %h exp %h", k, a_dat, w1[k]); end
      checks++; if (a_last !== 1'b0) begin errors++; $display("FAIL single_last beat %0d got %b exp 0", k, a_last); end
    end
    @(negedge clk); #1;
    checks++; if (a_vld !== 1'b0) begin errors++; $display("FAIL single_empty got %b exp 0", a_vld); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e;
    @(negedge clk);
    a_sv = 1'b1; a_sd = 32'h44332211; a_sl = 1'b0; a_rdy = 1'b1;
    #1;
    checks++; if (a_srdy !== 1'b1) begin errors++; $display("FAIL b2b_first_ready got %b exp 1", a_srdy); end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      a_sv = (k < 4); a_sd = 32'h88776655;
      #1;
      e = (k < 4) ? w1[k] : w2[k-4];
      checks++; if (a_vld !== 1'b1) begin errors++; $display("FAIL b2b_valid beat %0d got %b exp 1", k, a_vld); end
      checks++; if (a_dat !== e) begin errors++; $display("FAIL b2b_data beat %0d got %h exp %h", k, a_dat, e); end
      if (k < 4) begin
        checks++; if (a_srdy !== (k == 3)) begin errors++; $display("FAIL b2b_sink_ready beat %0d got %b exp %b", k, a_srdy, (k == 3)); end
      end
    end
    @(negedge clk); #1;
    checks++; if (a_vld !== 1'b0) begin errors++; $display("FAIL b2b_empty got %b exp 0", a_vld); end
  endtask

  task automatic test_partial();
    @(negedge clk);
    a_sv = 1'b1; a_sd = 32'hDDCCBBAA; a_sl = 1'b1; a_snb = 2'd3; a_rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      a_sv = 1'b0; a_sl = 1'b0; a_snb = 2'd0;
      #1;
      checks++; if (a_dat !== pe[k] || a_vld !== 1'b1) begin errors++; $display("FAIL partial_data beat %0d got %h/%b exp %h/1", k, a_dat, a_vld, pe[k]); end
      checks++; if (a_last !== (k == 2)) begin errors++; $display("FAIL partial_last beat %0d got %b exp %b", k, a_last, (k == 2)); end
    end
    @(negedge clk); #1;
    checks++; if (a_vld !== 1'b0) begin errors++; $display("FAIL partial_empty got %b exp 0", a_vld); end
  endtask

  task automatic test_partial16();
    @(negedge clk);
    b_sv = 1'b1; b_sd = 32'hDDCCBBAA; b_sl = 1'b1; b_snb = 2'd3; b_rdy = 1'b1;
    #1;
    checks++; if (b_srdy !== 1'b1) begin errors++; $display("FAIL p16_sink_ready got %b exp 1", b_srdy); end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      b_sv = 1'b0;
      #1;
      checks++; if (b_dat !== p16[k] || b_vld !== 1'b1) begin errors++; $display("FAIL p16_data beat %0d got %h/%b exp %h/1", k, b_dat, b_vld, p16[k]); end
      checks++; if (b_last !== (k == 1)) begin errors++; $display("FAIL p16_last beat %0d got %b exp %b", k, b_last, (k == 1)); end
    end
    @(negedge clk); #1;
    checks++; if (b_vld !== 1'b0) begin errors++; $display("FAIL p16_empty got %b exp 0", b_vld); end
  endtask

  task automatic test_flush();
    @(negedge clk);
    a_sv = 1'b1; a_sd = 32'h44332211; a_sl = 1'b0; a_snb = 2'd0; a_rdy = 1'b1;
    @(negedge clk);
    a_sv = 1'b0;
    #1;
    checks++; if (a_dat !== w1[0]) begin errors++; $display("FAIL flush_first_beat got %h exp %h", a_dat, w1[0]); end
    @(negedge clk);
    a_fl = 1'b1; a_sv = 1'b1; a_sd = 32'h000000EE;
    #1;
    checks++; if (a_srdy !== 1'b0) begin errors++; $display("FAIL flush_sink_ready got %b exp 0", a_srdy); end
    @(negedge clk);
    a_fl = 1'b0;
    #1;
    checks++; if (a_vld !== 1'b0) begin errors++; $display("FAIL flush_cleared got %b exp 0", a_vld); end
    checks++; if (a_srdy !== 1'b1) begin errors++; $display("FAIL flush_after_ready got %b exp 1", a_srdy); end
    @(negedge clk);
    a_sv = 1'b0;
    #1;
    checks++; if (a_vld !== 1'b1 || a_dat !== ee_first) begin errors++; $display("FAIL flush_new_word got %h/%b exp %h/1", a_dat, a_vld, ee_first); end
    repeat (4) @(negedge clk);
    #1;
    checks++; if (a_vld !== 1'b0) begin errors++; $display("FAIL flush_drain got %b exp 0", a_vld); end
    // Flush while empty only masks sink readiness for that cycle.
    @(negedge clk);
    a_fl = 1'b1; a_sv = 1'b1; a_sd = 32'h12345678;
    #1;
    checks++; if (a_srdy !== 1'b0) begin errors++; $display("FAIL flush_empty_ready got %b exp 0", a_srdy); end
    @(negedge clk);
    a_fl = 1'b0; a_sv = 1'b0;
    #1;
    checks++; if (a_vld !== 1'b0) begin errors++; $display("FAIL flush_empty_noload got %b exp 0", a_vld); end
  endtask

  task automatic test_stall();
    @(negedge clk);
    a_sv = 1'b1; a_sd = 32'h44332211; a_sl = 1'b0; a_rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      a_sv = 1'b0; a_rdy = 1'b0;
      #1;
      checks++; if (a_vld !== 1'b1 || a_dat !== w1[0] || a_last !== 1'b0) begin errors++; $display("FAIL stall_hold cycle %0d got %h/%b/%b exp %h/1/0", k, a_dat, a_vld, a_last, w1[0]); end
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      a_rdy = 1'b1;
      #1;
      checks++; if (a_dat !== w1[k]) begin errors++; $display("FAIL stall_drain beat %0d got %h exp %h", k, a_dat, w1[k]); end
    end
    @(negedge clk); #1;
    checks++; if (a_vld !== 1'b0) begin errors++; $display("FAIL stall_empty got %b exp 0", a_vld); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    a_sv = 1'b1; a_sd = 32'h44332211; a_sl = 1'b0; a_rdy = 1'b1;
    @(negedge clk);
    a_sv = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (a_vld !== 1'b0 || a_dat !== 8'h00 || a_last !== 1'b0) begin errors++; $display("FAIL async_reset got %h/%b/%b exp 00/0/0", a_dat, a_vld, a_last); end
    checks++; if (a_srdy !== 1'b1) begin errors++; $display("FAIL async_reset_ready got %b exp 1", a_srdy); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    checks++; if (a_vld !== 1'b0) begin errors++; $display("FAIL async_reset_discard got %b exp 0", a_vld); end
  endtask

  task automatic test_random();
    logic exp_rdy;
    int   nb;
    beat_t bt;
    q.delete();
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      a_sv  = ($urandom_range(0, 3) != 0);
      a_sd  = $urandom;
      a_sl  = ($urandom_range(0, 2) == 0);
      a_snb = 2'($urandom_range(0, 3));
      a_rdy = ($urandom_range(0, 3) != 0);
      a_fl  = ($urandom_range(0, 30) == 0);
      #1;
      exp_rdy = !a_fl && (q.size() == 0 || (q.size() == 1 && a_rdy));
      checks++; if (a_srdy !== exp_rdy) begin errors++; $display("FAIL rand_sink_ready cyc %0d got %b exp %b", c, a_srdy, exp_rdy); end
      checks++; if (a_vld !== (q.size() != 0)) begin errors++; $display("FAIL rand_valid cyc %0d got %b exp %b", c, a_vld, (q.size() != 0)); end
      if (q.size() != 0) begin
        checks++; if (a_dat !== q[0].d || a_last !== q[0].l) begin errors++; $display("FAIL rand_beat cyc %0d got %h/%b exp %h/%b", c, a_dat, a_last, q[0].d, q[0].l); end
      end
      if (a_fl) q.delete();
      else begin
        if (a_rdy && q.size() != 0) void'(q.pop_front());
        if (a_sv && exp_rdy) begin
          nb = a_sl ? ((a_snb == 2'd0) ? 4 : int'(a_snb)) : 4;
          for (int i = 0; i < nb; i++) begin
`ifdef WIDTH_DOWNSIZER_MSB_FIRST_EN
            bt.d = a_sd[(3 - i)*8 +: 8];
`else
            bt.d = a_sd[i*8 +: 8];
`endif
            bt.l = a_sl && (i == nb - 1);
            q.push_back(bt);
          end
        end
      end
    end
    @(negedge clk);
    a_sv = 1'b0; a_fl = 1'b0; a_rdy = 1'b1;
  endtask

  initial begin
`ifdef WIDTH_DOWNSIZER_MSB_FIRST_EN
    w1 = '{8'h44, 8'h33, 8'h22, 8'h11};
    w2 = '{8'h88, 8'h77, 8'h66, 8'h55};
    pe = '{8'hDD, 8'hCC, 8'hBB};
    p16 = '{16'hDDCC, 16'hBB00};
    ee_first = 8'h00;
`else
    w1 = '{8'h11, 8'h22, 8'h33, 8'h44};
    w2 = '{8'h55, 8'h66, 8'h77, 8'h88};
    pe = '{8'hAA, 8'hBB, 8'hCC};
    p16 = '{16'hBBAA, 16'h00CC};
    ee_first = 8'hEE;
`endif
    a_sv = 1'b0; a_sd = '0; a_sl = 1'b0; a_snb = '0; a_rdy = 1'b1; a_fl = 1'b0;
    b_sv = 1'b0; b_sd = '0; b_sl = 1'b0; b_snb = '0; b_rdy = 1'b1; b_fl = 1'b0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_partial();
    test_partial16();
    test_flush();
    test_stall();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
